// File: rtl/synapse_stdp_pop_pkg.sv
// Shared definitions for the synapse_stdp_pop block.
// Contents:
//   state_e          sweep FSM encoding (init / idle / read / write)
//   Def*             default population and STDP constants
//   sat_u64          unsigned saturation to an arbitrary width (<= 63 bits)
//   clamp_s64        signed clamp to [lo, hi]
package synapse_stdp_pop_pkg;

    typedef enum logic [1:0] {
        StInit = 2'd0,
        StIdle = 2'd1,
        StRd   = 2'd2,
        StWr   = 2'd3
    } state_e;

    localparam int unsigned DefNSyn       = 128;
    localparam int unsigned DefAddrW      = 7;
    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefHistW      = 32;
    localparam int unsigned DefDecayShift = 3;
    localparam int unsigned DefWInit      = 10240;
    localparam int unsigned DefLtpStep    = 1024;
    localparam int unsigned DefLtdStep    = 512;
    localparam int unsigned DefWMin       = 0;
    localparam int unsigned DefWMax       = 65535;

    function automatic logic [63:0] sat_u64(input logic [63:0] v, input int unsigned width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic [63:0] clamp_s64(input logic signed [63:0] v,
                                              input logic signed [63:0] lo,
                                              input logic signed [63:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/synapse_stdp_pop_if.sv
// Frame-control and per-synapse result bundle of synapse_stdp_pop.
// master: frame source / result consumer (drives frame_start, spikes, learn_en)
// slave:  the synapse population (drives busy, done, each_*, I_sum)
interface synapse_stdp_pop_if #(
    parameter int unsigned N_SYN  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic                     frame_start;
    logic [N_SYN-1:0]         spike_in;
    logic                     post_spike_in;
    logic                     learn_en;
    logic                     busy;
    logic                     done;
    logic                     each_valid;
    logic [ADDR_W-1:0]        each_idx;
    logic [DATA_W-1:0]        each_I;
    logic [DATA_W-1:0]        each_w;
    logic [DATA_W+ADDR_W-1:0] I_sum;

    modport master (
        output frame_start, spike_in, post_spike_in, learn_en,
        input  busy, done, each_valid, each_idx, each_I, each_w, I_sum
    );

    modport slave (
        input  frame_start, spike_in, post_spike_in, learn_en,
        output busy, done, each_valid, each_idx, each_I, each_w, I_sum
    );
endinterface

// File: rtl/syn_state_ram.sv
// Per-synapse state store: single clock, one shared read/write port,
// synchronous (registered) read. Word layout is chosen by the user.
// Ports: clk, we (write enable), addr, wdata, rdata (valid the cycle after addr).
module syn_state_ram #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned WORD_W = 96
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/synapse_stdp_pop.sv
// Time-multiplexed population of N_SYN plastic synapses feeding one neuron.
// After reset every synapse is initialised ({i=0, w=W_INIT, hist=0}); each
// frame_start then sweeps all synapses (read slot, write slot per synapse),
// applying current decay, presynaptic impulses and pair-based STDP.
// Ports: clk, reset_bar (async, active low),
//        bus (slave): frame_start/spike_in/post_spike_in/learn_en in,
//        busy/done/each_valid/each_idx/each_I/each_w/I_sum out.
module synapse_stdp_pop
    import synapse_stdp_pop_pkg::*;
#(
    parameter int unsigned N_SYN       = DefNSyn,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned HIST_W      = DefHistW,
    parameter int unsigned DECAY_SHIFT = DefDecayShift,
    parameter int unsigned W_INIT      = DefWInit,
    parameter int unsigned LTP_STEP    = DefLtpStep,
    parameter int unsigned LTD_STEP    = DefLtdStep,
    parameter int unsigned W_MIN       = DefWMin,
    parameter int unsigned W_MAX       = DefWMax
) (
    input logic               clk,
    input logic               reset_bar,
    synapse_stdp_pop_if.slave bus
);
    localparam int unsigned WordW = 2 * DATA_W + HIST_W;
    localparam int unsigned SumW  = DATA_W + ADDR_W;
    localparam logic signed [DATA_W+1:0] LtpS = (DATA_W + 2)'(LTP_STEP);
    localparam logic signed [DATA_W+1:0] LtdS = (DATA_W + 2)'(LTD_STEP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [N_SYN-1:0]    spike_q;
    logic                post_q;
    logic [HIST_W-1:0]   post_hist_q;
    logic [SumW-1:0]     acc_q;
    logic [SumW-1:0]     i_sum_q;
    logic                done_q;

    logic                ram_we;
    logic [WordW-1:0]    ram_wdata, ram_rdata;
    logic [DATA_W-1:0]   cur_i, cur_w, i_next, w_next, w_clamped, decay;
    logic [HIST_W-1:0]   cur_hist, hist_next;
    logic [63:0]         i_wide;
    logic signed [DATA_W+1:0] w_calc;
    logic                pre, ltp, ltd, is_last;

    syn_state_ram #(
        .DEPTH  (N_SYN),
        .ADDR_W (ADDR_W),
        .WORD_W (WordW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign cur_i    = ram_rdata[WordW-1 -: DATA_W];
    assign cur_w    = ram_rdata[HIST_W +: DATA_W];
    assign cur_hist = ram_rdata[HIST_W-1:0];
    assign pre      = spike_q[idx_q];
    assign is_last  = (idx_q == ADDR_W'(N_SYN - 1));

    // Synapse update; all terms use the pre-update memory word.
    always_comb begin
        decay     = cur_i - (cur_i >> DECAY_SHIFT);
        i_wide    = 64'(decay) + (pre ? 64'(cur_w) : 64'd0);
        i_next    = DATA_W'(sat_u64(i_wide, DATA_W));
        ltp       = post_q && (cur_hist != '0);
        ltd       = pre && (post_hist_q != '0);
        w_calc    = $signed({2'b00, cur_w});
        if (ltp) w_calc = w_calc + LtpS;
        if (ltd) w_calc = w_calc - LtdS;
        w_clamped = DATA_W'(clamp_s64(64'(w_calc), 64'(W_MIN), 64'(W_MAX)));
        w_next    = bus.learn_en ? w_clamped : cur_w;
        hist_next = {cur_hist[HIST_W-2:0], pre};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) state_q <= StInit;
        else            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (is_last) state_d = StIdle;
            StIdle:  if (bus.frame_start) state_d = StRd;
            StRd:    state_d = StWr;
            StWr:    state_d = is_last ? StIdle : StRd;
            default: state_d = StInit;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ram_we    = (state_q == StInit) || (state_q == StWr);
        ram_wdata = (state_q == StInit)
                  ? {{DATA_W{1'b0}}, DATA_W'(W_INIT), {HIST_W{1'b0}}}
                  : {i_next, w_next, hist_next};
        // busy is gated by reset so every output reads 0 while reset is held
        bus.busy       = reset_bar && (state_q != StIdle);
        bus.each_valid = (state_q == StWr);
        bus.each_idx   = bus.each_valid ? idx_q  : '0;
        bus.each_I     = bus.each_valid ? i_next : '0;
        bus.each_w     = bus.each_valid ? w_next : '0;
        bus.done       = done_q;
        bus.I_sum      = i_sum_q;
    end

    // Sweep datapath: index, latched frame inputs, accumulator, post history
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            idx_q       <= '0;
            spike_q     <= '0;
            post_q      <= 1'b0;
            post_hist_q <= '0;
            acc_q       <= '0;
            i_sum_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StInit: idx_q <= is_last ? '0 : idx_q + 1'b1;
                StIdle: begin
                    if (bus.frame_start) begin
                        spike_q <= bus.spike_in;
                        post_q  <= bus.post_spike_in;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                StRd: ;
                StWr: begin
                    acc_q <= acc_q + SumW'(i_next);
                    if (is_last) begin
                        idx_q       <= '0;
                        i_sum_q     <= acc_q + SumW'(i_next);
                        done_q      <= 1'b1;
                        // shifted only after the sweep so all synapses see last frame's value
                        post_hist_q <= {post_hist_q[HIST_W-2:0], post_q};
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_synapse_stdp_pop.sv
// Scoreboard bench for synapse_stdp_pop: two 4-synapse instances, one with the
// default weight ceiling (dut_a) and one with W_MAX=10752 (dut_b).
module tb_synapse_stdp_pop;
    localparam int unsigned NS = 4;

    logic clk = 1'b0;
    logic reset_bar = 1'b0;
    always #5 clk = ~clk;

    synapse_stdp_pop_if #(.N_SYN(NS), .ADDR_W(2), .DATA_W(32)) ifa ();
    synapse_stdp_pop_if #(.N_SYN(NS), .ADDR_W(2), .DATA_W(32)) ifb ();

    synapse_stdp_pop #(.N_SYN(NS), .ADDR_W(2)) dut_a (
        .clk       (clk),
        .reset_bar (reset_bar),
        .bus       (ifa)
    );

    synapse_stdp_pop #(.N_SYN(NS), .ADDR_W(2), .W_MAX(10752)) dut_b (
        .clk       (clk),
        .reset_bar (reset_bar),
        .bus       (ifb)
    );

    typedef struct {
        int unsigned idx;
        logic [31:0] i;
        logic [31:0] w;
    } exp_t;

    exp_t        q_a[$], q_b[$];
    logic [33:0] s_a[$], s_b[$];
    int n_cmp = 0, n_bad = 0;
    int n_valid_a = 0, n_done_a = 0, n_valid_b = 0, n_done_b = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push1(input bit sel, input int unsigned idx, input logic [31:0] i,
                         input logic [31:0] w);
        exp_t e;
        e.idx = idx; e.i = i; e.w = w;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic push4(input bit sel,
                         input logic [31:0] i0, input logic [31:0] w0,
                         input logic [31:0] i1, input logic [31:0] w1,
                         input logic [31:0] i2, input logic [31:0] w2,
                         input logic [31:0] i3, input logic [31:0] w3,
                         input logic [33:0] sum);
        push1(sel, 0, i0, w0);
        push1(sel, 1, i1, w1);
        push1(sel, 2, i2, w2);
        push1(sel, 3, i3, w3);
        if (sel) s_b.push_back(sum);
        else     s_a.push_back(sum);
    endtask

    task automatic drive(input bit sel, input bit fs, input logic [3:0] spk, input bit post,
                         input bit learn);
        if (sel) begin
            ifb.frame_start = fs; ifb.spike_in = spk;
            ifb.post_spike_in = post; ifb.learn_en = learn;
        end else begin
            ifa.frame_start = fs; ifa.spike_in = spk;
            ifa.post_spike_in = post; ifa.learn_en = learn;
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents a result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_bar && ifa.each_valid) begin
                n_valid_a++;
                if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_idx", ifa.each_idx, e.idx);
                    chk($sformatf("a_I[%0d]", e.idx), ifa.each_I, e.i);
                    chk($sformatf("a_w[%0d]", e.idx), ifa.each_w, e.w);
                end
            end
            if (reset_bar && ifa.done) begin
                n_done_a++;
                if (s_a.size() == 0) chk("a_unexpected_done", 1, 0);
                else chk("a_I_sum", ifa.I_sum, s_a.pop_front());
            end
            if (reset_bar && ifb.each_valid) begin
                n_valid_b++;
                if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_idx", ifb.each_idx, e.idx);
                    chk($sformatf("b_I[%0d]", e.idx), ifb.each_I, e.i);
                    chk($sformatf("b_w[%0d]", e.idx), ifb.each_w, e.w);
                end
            end
            if (reset_bar && ifb.done) begin
                n_done_b++;
                if (s_b.size() == 0) chk("b_unexpected_done", 1, 0);
                else chk("b_I_sum", ifb.I_sum, s_b.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, ifa.busy, 0);
        chk({tag, "_done"}, ifa.done, 0);
        chk({tag, "_valid"}, ifa.each_valid, 0);
        chk({tag, "_idx"}, ifa.each_idx, 0);
        chk({tag, "_I"}, ifa.each_I, 0);
        chk({tag, "_w"}, ifa.each_w, 0);
        chk({tag, "_I_sum"}, ifa.I_sum, 0);
    endtask

    // Called right after reset release: INIT must hold busy for exactly NS cycles
    task automatic count_busy();
        int na, nb;
        na = 0; nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifa.busy) na++;
            if (ifb.busy) nb++;
        end
        chk("a_init_busy_cycles", na, NS);
        chk("b_init_busy_cycles", nb, NS);
    endtask

    task automatic run_frame(input bit sel, input logic [3:0] spk, input bit post,
                             input bit learn, input bit mid_pulse);
        int v0, d0, lat;
        bit got;
        v0 = sel ? n_valid_b : n_valid_a;
        d0 = sel ? n_done_b : n_done_a;
        @(posedge clk); #2;
        drive(sel, 1'b1, spk, post, learn);
        @(negedge clk);                       // cycle 0
        @(posedge clk); #2;
        drive(sel, 1'b0, spk, post, learn);
        got = 1'b0; lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (mid_pulse && c == 3) drive(sel, 1'b1, spk, post, learn);
            if (mid_pulse && c == 4) drive(sel, 1'b0, spk, post, learn);
            if (sel ? ifb.done : ifa.done) begin got = 1'b1; lat = c; end
        end
        chk("done_latency", lat, 2 * NS + 1);
        repeat (4) @(negedge clk);
        chk("busy_after_sweep", sel ? ifb.busy : ifa.busy, 0);
        chk("valid_count", (sel ? n_valid_b : n_valid_a) - v0, NS);
        chk("done_count", (sel ? n_done_b : n_done_a) - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 4'b0000, 1'b0, 1'b1);
        drive(1, 1'b0, 4'b0000, 1'b0, 1'b1);
        reset_bar = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #2 reset_bar = 1'b1;
        count_busy();

        // A: empty frame, then decay / LTP / LTD / freeze / both-rules / mid pulse
        push4(0, 0, 10240, 0, 10240, 0, 10240, 0, 10240, 0);
        run_frame(0, 4'b0000, 1'b0, 1'b1, 1'b0);
        push4(0, 10240, 10240, 0, 10240, 0, 10240, 0, 10240, 10240);
        run_frame(0, 4'b0001, 1'b0, 1'b1, 1'b0);
        push4(0, 8960, 11264, 0, 10240, 0, 10240, 0, 10240, 8960);
        run_frame(0, 4'b0000, 1'b1, 1'b1, 1'b0);
        push4(0, 7840, 11264, 10240, 9728, 0, 10240, 0, 10240, 18080);
        run_frame(0, 4'b0010, 1'b0, 1'b1, 1'b0);
        push4(0, 18124, 11264, 18688, 9728, 0, 10240, 0, 10240, 36812);
        run_frame(0, 4'b0011, 1'b1, 1'b0, 1'b0);
        push4(0, 27123, 11776, 16352, 10752, 0, 10240, 0, 10240, 43475);
        run_frame(0, 4'b0001, 1'b1, 1'b1, 1'b0);
        push4(0, 23733, 11776, 14308, 10752, 0, 10240, 0, 10240, 38041);
        run_frame(0, 4'b0000, 1'b0, 1'b1, 1'b1);

        // B: weight ceiling at 10752
        push4(1, 10240, 10240, 0, 10240, 0, 10240, 0, 10240, 10240);
        run_frame(1, 4'b0001, 1'b0, 1'b1, 1'b0);
        push4(1, 8960, 10752, 0, 10240, 0, 10240, 0, 10240, 8960);
        run_frame(1, 4'b0000, 1'b1, 1'b1, 1'b0);
        push4(1, 7840, 10752, 0, 10240, 0, 10240, 0, 10240, 7840);
        run_frame(1, 4'b0000, 1'b1, 1'b1, 1'b0);

        // A: reset during cycle 5 of a sweep; only slots 0 and 1 come out
        push1(0, 0, 32543, 11264);
        push1(0, 1, 23272, 10240);
        @(posedge clk); #2;
        drive(0, 1'b1, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        @(posedge clk); #2;
        drive(0, 1'b0, 4'b1111, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk); #2 reset_bar = 1'b0;
        #1 check_zero("mid_reset");
        repeat (3) @(negedge clk);
        check_zero("mid_reset_hold");
        @(posedge clk); #2 reset_bar = 1'b1;
        count_busy();
        push4(0, 0, 10240, 0, 10240, 0, 10240, 0, 10240, 0);
        run_frame(0, 4'b0000, 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("a_pending_results", q_a.size(), 0);
        chk("b_pending_results", q_b.size(), 0);
        chk("a_pending_sums", s_a.size(), 0);
        chk("b_pending_sums", s_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
